// File: rtl/video_scan_out.sv
// video_scan_out: raster timing generator and blank-gated, sync-aligned video output stage
module video_scan_out #(
    parameter int H_DISPLAY = 256,
    parameter int H_FRONT   = 7,
    parameter int H_SYNC    = 23,
    parameter int H_BACK    = 23,
    parameter int V_DISPLAY = 240,
    parameter int V_BOTTOM  = 14,
    parameter int V_SYNC    = 3,
    parameter int V_TOP     = 5,
    parameter int PIPE      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rgb_in,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] rgb_out
);
    localparam logic [8:0] H_LAST   = 9'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [8:0] V_LAST   = 9'(V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1);
    localparam logic [8:0] H_VIS    = 9'(H_DISPLAY);
    localparam logic [8:0] V_VIS    = 9'(V_DISPLAY);
    localparam logic [8:0] HS_FIRST = 9'(H_DISPLAY + H_FRONT);
    localparam logic [8:0] HS_LAST  = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [8:0] VS_FIRST = 9'(V_DISPLAY + V_BOTTOM);
    localparam logic [8:0] VS_LAST  = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    logic       hsRaw;
    logic       vsRaw;
    logic [2:0] tail;

    assign display_on  = (hpos < H_VIS) && (vpos < V_VIS);
    assign line_start  = (hpos == 9'd0);
    assign frame_start = (hpos == 9'd0) && (vpos == 9'd0);
    assign hsRaw       = (hpos >= HS_FIRST) && (hpos <= HS_LAST);
    assign vsRaw       = (vpos >= VS_FIRST) && (vpos <= VS_LAST);

    // Raster counters; frame count advances on the same edge both counters wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos      <= '0;
            vpos      <= '0;
            frame_cnt <= '0;
        end else begin
            hpos <= (hpos == H_LAST) ? 9'd0 : hpos + 9'd1;
            if (hpos == H_LAST) begin
                vpos <= (vpos == V_LAST) ? 9'd0 : vpos + 9'd1;
                if (vpos == V_LAST) frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    generate
        if (PIPE > 0) begin : gDelay
            logic [2:0] dly [PIPE];
            // Delay sync and blank flags to match the latency of the layer pipeline
            always_ff @(posedge clk) begin
                if (reset) begin
                    dly <= '{default: '0};
                end else begin
                    dly[0] <= {hsRaw, vsRaw, display_on};
                    for (int k = PIPE - 1; k > 0; k--) dly[k] <= dly[k-1];
                end
            end
            assign tail = dly[PIPE-1];
        end else begin : gDirect
            assign tail = {hsRaw, vsRaw, display_on};
        end
    endgenerate

    // Shared output register keeps sync and colour on the same pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync   <= 1'b0;
            vsync   <= 1'b0;
            rgb_out <= 4'b0000;
        end else begin
            hsync   <= tail[2];
            vsync   <= tail[1];
            rgb_out <= tail[0] ? rgb_in : 4'b0000;
        end
    end
endmodule

// File: tb/tb_video_scan_out.sv
// tb_video_scan_out: scoreboard plus table-driven checks of the raster generator
module tb_video_scan_out;
    localparam int HD[3] = '{256, 8, 8};
    localparam int HF[3] = '{7, 2, 2};
    localparam int HS[3] = '{23, 3, 3};
    localparam int HB[3] = '{23, 2, 2};
    localparam int VD[3] = '{240, 4, 4};
    localparam int VB[3] = '{14, 1, 1};
    localparam int VS[3] = '{3, 2, 2};
    localparam int VT[3] = '{5, 1, 1};
    localparam int PP[3] = '{1, 0, 3};

    typedef struct {
        logic       hs;
        logic       vs;
        logic [3:0] rgb;
    } exp_t;

    typedef struct {
        int         adv;
        int         h;
        int         v;
        logic       hs;
        logic [3:0] rgb;
        logic       ls;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [3:0] rgbIn;
    logic [8:0] hp [3];
    logic [8:0] vp [3];
    logic       don [3];
    logic       ls [3];
    logic       fs [3];
    logic [7:0] fc [3];
    logic       hs [3];
    logic       vs [3];
    logic [3:0] ro [3];

    int   checks = 0;
    int   errors = 0;
    int   mh [3];
    int   mv [3];
    int   mf [3];
    logic [2:0] dl [3][0:4];
    exp_t expQ[$];

    for (genvar g = 0; g < 3; g++) begin : gDut
        video_scan_out #(
            .H_DISPLAY(HD[g]), .H_FRONT(HF[g]), .H_SYNC(HS[g]), .H_BACK(HB[g]),
            .V_DISPLAY(VD[g]), .V_BOTTOM(VB[g]), .V_SYNC(VS[g]), .V_TOP(VT[g]),
            .PIPE(PP[g])
        ) dut (
            .clk(clk), .reset(reset), .rgb_in(rgbIn),
            .hpos(hp[g]), .vpos(vp[g]), .display_on(don[g]),
            .line_start(ls[g]), .frame_start(fs[g]), .frame_cnt(fc[g]),
            .hsync(hs[g]), .vsync(vs[g]), .rgb_out(ro[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [2:0] attr(input int i, input int h, input int v);
        int hss = HD[i] + HF[i];
        int vss = VD[i] + VB[i];
        return {h >= hss && h < hss + HS[i], v >= vss && v < vss + VS[i], h < HD[i] && v < VD[i]};
    endfunction

    task automatic step(input logic r, input logic [3:0] rgb);
        logic [2:0] t;
        exp_t e;
        reset = r;
        rgbIn = rgb;
        for (int i = 0; i < 3; i++) begin
            for (int k = PP[i]; k > 0; k--) dl[i][k] = dl[i][k-1];
            dl[i][0] = attr(i, mh[i], mv[i]);
            t = dl[i][PP[i]];
            expQ.push_back('{t[2], t[1], t[0] ? rgb : 4'h0});
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            e = expQ.pop_front();
            if (r) begin
                mh[i] = 0;
                mv[i] = 0;
                mf[i] = 0;
                for (int k = 0; k < 5; k++) dl[i][k] = 3'b000;
                e = '{1'b0, 1'b0, 4'h0};
            end else if (mh[i] == HD[i] + HF[i] + HS[i] + HB[i] - 1) begin
                mh[i] = 0;
                if (mv[i] == VD[i] + VB[i] + VS[i] + VT[i] - 1) begin
                    mv[i] = 0;
                    mf[i] = (mf[i] + 1) % 256;
                end else mv[i]++;
            end else mh[i]++;
            check($sformatf("hpos%0d", i), int'(hp[i]), mh[i]);
            check($sformatf("vpos%0d", i), int'(vp[i]), mv[i]);
            check($sformatf("frame_cnt%0d", i), int'(fc[i]), mf[i]);
            check($sformatf("display_on%0d", i), int'(don[i]), int'(attr(i, mh[i], mv[i]) & 3'b001));
            check($sformatf("line_start%0d", i), int'(ls[i]), int'(mh[i] == 0));
            check($sformatf("frame_start%0d", i), int'(fs[i]), int'(mh[i] == 0 && mv[i] == 0));
            check($sformatf("hsync%0d", i), int'(hs[i]), int'(e.hs));
            check($sformatf("vsync%0d", i), int'(vs[i]), int'(e.vs));
            check($sformatf("rgb_out%0d", i), int'(ro[i]), int'(e.rgb));
        end
    endtask

    initial begin
        vec_t vt[11];
        int cnt;
        int cntB;
        int n;
        vt[0]  = '{1,   1,   0, 1'b0, 4'h0, 1'b0};
        vt[1]  = '{1,   2,   0, 1'b0, 4'h3, 1'b0};
        vt[2]  = '{255, 257, 0, 1'b0, 4'h3, 1'b0};
        vt[3]  = '{1,   258, 0, 1'b0, 4'h0, 1'b0};
        vt[4]  = '{6,   264, 0, 1'b0, 4'h0, 1'b0};
        vt[5]  = '{1,   265, 0, 1'b1, 4'h0, 1'b0};
        vt[6]  = '{22,  287, 0, 1'b1, 4'h0, 1'b0};
        vt[7]  = '{1,   288, 0, 1'b0, 4'h0, 1'b0};
        vt[8]  = '{20,  308, 0, 1'b0, 4'h0, 1'b0};
        vt[9]  = '{1,   0,   1, 1'b0, 4'h0, 1'b1};
        vt[10] = '{2,   2,   1, 1'b0, 4'h3, 1'b0};
        for (int i = 0; i < 3; i++) begin
            mh[i] = 0;
            mv[i] = 0;
            mf[i] = 0;
            for (int k = 0; k < 5; k++) dl[i][k] = 3'b000;
        end
        reset = 1'b1;
        rgbIn = 4'h0;
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        check("rst_hpos", int'(hp[0]), 0);
        check("rst_vpos", int'(vp[0]), 0);
        check("rst_frame_start", int'(fs[0]), 1);
        check("rst_line_start", int'(ls[0]), 1);
        check("rst_rgb_out", int'(ro[0]), 0);
        check("rst_hsync", int'(hs[0]), 0);
        check("rst_vsync", int'(vs[0]), 0);
        for (int r = 0; r < 11; r++) begin
            repeat (vt[r].adv) step(1'b0, 4'b0011);
            check($sformatf("vec%0d_hpos", r), int'(hp[0]), vt[r].h);
            check($sformatf("vec%0d_vpos", r), int'(vp[0]), vt[r].v);
            check($sformatf("vec%0d_hsync", r), int'(hs[0]), int'(vt[r].hs));
            check($sformatf("vec%0d_rgb", r), int'(ro[0]), int'(vt[r].rgb));
            check($sformatf("vec%0d_line_start", r), int'(ls[0]), int'(vt[r].ls));
        end
        cnt = 0;
        cntB = 0;
        repeat (309) begin
            step(1'b0, 4'($urandom));
            if (ls[0]) cnt++;
            if (hs[0]) cntB++;
        end
        check("line_start_per_line", cnt, 1);
        check("hsync_width", cntB, 23);
        step(1'b1, 4'h0);
        cnt = 0;
        repeat (120) begin
            step(1'b0, 4'($urandom));
            if (vs[1]) cnt++;
        end
        check("vsync_clocks_small", cnt, 30);
        step(1'b1, 4'h0);
        cnt = 0;
        for (int s = 1; s <= 256 * 120; s++) begin
            step(1'b0, 4'($urandom));
            if (fs[1]) cnt++;
            if (s == 256 * 120 - 1) check("frame_cnt_before_wrap", int'(fc[1]), 255);
        end
        check("frame_cnt_wrap", int'(fc[1]), 0);
        check("frame_start_count", cnt, 256);
        repeat (240) step(1'b0, 4'($urandom));
        check("frame_cnt_two", int'(fc[1]), 2);
        n = 0;
        while (!(hp[1] == 9'd12 && vp[1] == 9'd5) && n < 400) begin
            step(1'b0, 4'($urandom));
            n++;
        end
        check("reach_sync_point", int'(hp[1] == 9'd12 && vp[1] == 9'd5), 1);
        check("pre_reset_hsync", int'(hs[1]), 1);
        check("pre_reset_vsync", int'(vs[1]), 1);
        step(1'b1, 4'hf);
        check("mid_reset_hsync", int'(hs[1]), 0);
        check("mid_reset_vsync", int'(vs[1]), 0);
        check("mid_reset_hpos", int'(hp[1]), 0);
        check("mid_reset_frame_cnt", int'(fc[1]), 0);
        check("mid_reset_rgb", int'(ro[1]), 0);
        step(1'b0, 4'hf);
        check("restart_hpos", int'(hp[1]), 1);
        check("restart_vpos", int'(vp[1]), 0);
        repeat (150) step(1'b0, 4'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
